// File: rtl/inst_loader_mem_if.sv
// AXI4 read-address / read-data channel bundle
// used between the instruction loader and DDR.
interface inst_loader_mem_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_BURST_WIDTH = 8
);
    logic [AXI_ADDR_WIDTH-1:0]  araddr;
    logic [AXI_BURST_WIDTH-1:0] arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic [AXI_ID_WIDTH-1:0]    arid;
    logic                       arvalid;
    logic                       arready;
    logic [AXI_DATA_WIDTH-1:0]  rdata;
    logic [1:0]                 rresp;
    logic [AXI_ID_WIDTH-1:0]    rid;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid, rready,
        input  arready, rdata, rresp, rid, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid, rready,
        output arready, rdata, rresp, rid, rlast, rvalid
    );
endinterface

// File: rtl/inst_loader_mem.sv
// Instruction memory with an AXI4 burst loader that
// unpacks wide beats into words, then serves the decoder.
module inst_loader_mem #(
    parameter int INST_WIDTH      = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_BURST_WIDTH = 8,
    parameter int MAX_BURST_LEN   = 16,
    parameter int IMEM_DEPTH      = 2048,
    parameter int IMEM_ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      start_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] start_base_addr,
    input  logic [IMEM_ADDR_W:0]      start_num_inst,
    output logic                      decoder_start,
    output logic                      load_error,
    input  logic                      s_read_req_b,
    input  logic [IMEM_ADDR_W-1:0]    s_read_addr_b,
    output logic [INST_WIDTH-1:0]     s_read_data_b,
    inst_loader_mem_if.master         m_axi
);
    localparam int WPB   = AXI_DATA_WIDTH / INST_WIDTH;
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = IMEM_ADDR_W + 1;
    localparam int SL_W  = (WPB > 1) ? $clog2(WPB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_n;

    logic [AXI_ADDR_WIDTH-1:0]  base_in, base_r, araddr_r;
    logic [AXI_BURST_WIDTH-1:0] arlen_r;
    logic [CNT_W-1:0]           n_clamp, n_beats, rem;
    logic [CNT_W-1:0]           num_r, beats_total, beats_issued, wptr;
    logic [AXI_DATA_WIDTH-1:0]  beat_buf;
    logic                       buf_valid;
    logic [SL_W-1:0]            slice;
    logic                       err_r;
    logic [INST_WIDTH-1:0]      rd_data;
    logic [INST_WIDTH-1:0]      mem [IMEM_DEPTH];
    logic                       accept, ar_hs, r_hs, wr_en, last_slice;
    logic                       unused_rid;

    // Beats in the next burst: capped at MAX_BURST_LEN, minus one.
    function automatic logic [AXI_BURST_WIDTH-1:0] burst_len(
        input logic [CNT_W-1:0] r
    );
        if (r == '0) return '0;
        if (r > CNT_W'(MAX_BURST_LEN))
            return AXI_BURST_WIDTH'(MAX_BURST_LEN - 1);
        return AXI_BURST_WIDTH'(r - CNT_W'(1));
    endfunction

    assign base_in = start_base_addr & ~AXI_ADDR_WIDTH'(BYTES - 1);
    assign n_clamp = (start_num_inst > CNT_W'(IMEM_DEPTH)) ?
                     CNT_W'(IMEM_DEPTH) : start_num_inst;
    assign n_beats = CNT_W'(({1'b0, n_clamp} + (CNT_W+1)'(WPB - 1))
                     / (CNT_W+1)'(WPB));
    assign rem        = beats_total - beats_issued;
    assign accept     = (state == S_IDLE) && start;
    assign ar_hs      = (state == S_AR) && m_axi.arready;
    assign r_hs       = m_axi.rvalid && m_axi.rready;
    assign wr_en      = buf_valid && !s_read_req_b && (wptr < num_r);
    assign last_slice = (slice == SL_W'(WPB - 1)) ||
                        (wptr + CNT_W'(1) == num_r);

    assign start_ready   = (state == S_IDLE);
    assign decoder_start = (state == S_DONE);
    assign load_error    = err_r;
    assign s_read_data_b = rd_data;

    assign m_axi.arvalid = (state == S_AR);
    assign m_axi.araddr  = araddr_r;
    assign m_axi.arlen   = arlen_r;
    assign m_axi.arsize  = 3'(OFF_W);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arid    = AXI_ID_WIDTH'(0);
    assign m_axi.rready  = (state == S_R) && !buf_valid;
    assign unused_rid    = ^m_axi.rid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic; the final rlast hands off to the drain wait.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start)
                         state_n = (n_clamp == '0) ? S_DONE : S_AR;
            S_AR:    if (m_axi.arready) state_n = S_R;
            S_R:     if (r_hs && m_axi.rlast)
                         state_n = (rem != '0) ? S_AR : S_DRAIN;
            S_DRAIN: if (!buf_valid && wptr == num_r) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Load parameters, burst bookkeeping and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r       <= '0;
            araddr_r     <= '0;
            arlen_r      <= '0;
            num_r        <= '0;
            beats_total  <= '0;
            beats_issued <= '0;
            err_r        <= 1'b0;
        end else begin
            if (accept) begin
                base_r       <= base_in;
                araddr_r     <= base_in;
                arlen_r      <= burst_len(n_beats);
                num_r        <= n_clamp;
                beats_total  <= n_beats;
                beats_issued <= '0;
                err_r        <= 1'b0;
            end
            if (ar_hs)
                beats_issued <= beats_issued + CNT_W'(arlen_r) + CNT_W'(1);
            if (r_hs && m_axi.rlast && rem != '0) begin
                araddr_r <= base_r +
                            (AXI_ADDR_WIDTH'(beats_issued) << OFF_W);
                arlen_r  <= burst_len(rem);
            end
            if (r_hs && m_axi.rresp != 2'b00)
                err_r <= 1'b1;
        end
    end

    // Beat buffer: shifts one word out per write, lowest slice first.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_buf  <= '0;
            buf_valid <= 1'b0;
            slice     <= '0;
            wptr      <= '0;
        end else begin
            if (accept) wptr <= '0;
            if (r_hs) begin
                beat_buf  <= m_axi.rdata;
                buf_valid <= 1'b1;
                slice     <= '0;
            end else if (wr_en) begin
                beat_buf <= beat_buf >> INST_WIDTH;
                slice    <= slice + SL_W'(1);
                wptr     <= wptr + CNT_W'(1);
                if (last_slice) buf_valid <= 1'b0;
            end else if (buf_valid && wptr >= num_r) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // RAM write port; stalled whenever the decoder reads.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[IMEM_ADDR_W-1:0]] <= beat_buf[INST_WIDTH-1:0];
    end

    // Decoder read port; data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (reset)             rd_data <= '0;
        else if (s_read_req_b) rd_data <= mem[s_read_addr_b];
    end
endmodule

// File: tb/tb_inst_loader_mem.sv
// Bench for inst_loader_mem: AXI slave model with a
// synthetic DDR image and a word-level memory model.
module tb_inst_loader_mem;
    localparam int DEPTH = 2048;
    localparam int WPB   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_ready;
    logic [31:0] start_base_addr = '0;
    logic [11:0] start_num_inst = '0;
    logic        decoder_start;
    logic        load_error;
    logic        s_read_req_b = 1'b0;
    logic [10:0] s_read_addr_b = '0;
    logic [31:0] s_read_data_b;

    always #5 clk = ~clk;

    inst_loader_mem_if m ();

    inst_loader_mem dut (
        .clk(clk), .reset(reset),
        .start(start), .start_ready(start_ready),
        .start_base_addr(start_base_addr),
        .start_num_inst(start_num_inst),
        .decoder_start(decoder_start), .load_error(load_error),
        .s_read_req_b(s_read_req_b), .s_read_addr_b(s_read_addr_b),
        .s_read_data_b(s_read_data_b),
        .m_axi(m)
    );

    int checks = 0, failures = 0;
    int cyc = 0, ds_cnt = 0, ds_cyc = 0, arv_cnt = 0;
    int ar_delay = 0, gap_pct = 0, err_beat = -1;
    int beats_sent = 0, ar_unstable = 0;
    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];
    logic [31:0] exp_mem[DEPTH];
    bit          exp_valid[DEPTH];
    int          start_cyc, ds0, ar0, ld_n;
    logic [31:0] ld_base;

    function automatic logic [31:0] ddr_word(input logic [31:0] w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Cycle monitor.
    always begin
        @(posedge clk); #1;
        cyc++;
        if (decoder_start) begin ds_cnt++; ds_cyc = cyc; end
        if (m.arvalid) arv_cnt++;
    end

    // AXI read slave backed by the DDR image.
    bit          s_busy = 0, ar_fire = 0, r_fire = 0, ar_hold = 0;
    int          beats_left = 0, ar_wait = 0, pend_len = 0, hold_len = 0;
    logic [31:0] cur_addr = 0, pend_addr = 0, hold_addr = 0;
    initial begin
        m.arready = 0; m.rvalid = 0; m.rdata = '0;
        m.rresp = 0; m.rid = 0; m.rlast = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m.arready = 0; m.rvalid = 0; m.rlast = 0;
                s_busy = 0; ar_fire = 0; r_fire = 0;
                ar_hold = 0; ar_wait = 0; beats_left = 0;
            end else begin
                if (ar_fire) begin
                    ar_addr_q.push_back(pend_addr);
                    ar_len_q.push_back(pend_len);
                    cur_addr = pend_addr; beats_left = pend_len + 1;
                    m.arready = 0; s_busy = 1;
                    ar_fire = 0; ar_hold = 0; ar_wait = 0;
                end
                if (r_fire) begin
                    m.rvalid = 0; m.rlast = 0; r_fire = 0;
                    beats_left--; cur_addr += 32;
                end
                if (s_busy && beats_left == 0) s_busy = 0;
                if (!s_busy) begin
                    if (m.arvalid) begin
                        if (!ar_hold) begin
                            hold_addr = m.araddr;
                            hold_len = int'(m.arlen);
                            ar_hold = 1;
                        end else if (m.araddr !== hold_addr ||
                                     int'(m.arlen) != hold_len) begin
                            ar_unstable++;
                        end
                        if (ar_wait >= ar_delay) m.arready = 1;
                        else ar_wait++;
                    end
                end else if (!m.rvalid) begin
                    if (int'($urandom_range(99)) >= gap_pct) begin
                        for (int i = 0; i < WPB; i++)
                            m.rdata[i*32 +: 32] = ddr_word((cur_addr >> 2) + i);
                        m.rresp = (beats_sent == err_beat) ? 2'b10 : 2'b00;
                        m.rlast = (beats_left == 1);
                        m.rvalid = 1;
                        beats_sent++;
                    end
                end
                ar_fire = m.arvalid && m.arready;
                if (ar_fire) begin
                    pend_addr = m.araddr; pend_len = int'(m.arlen);
                end
                r_fire = m.rvalid && m.rready;
            end
        end
    end

    task automatic start_load(input logic [31:0] base, input int n,
                              output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_ready) begin ok = 1; break; end
        end
        if (!ok) return;
        ds0 = ds_cnt; ar0 = ar_len_q.size();
        ld_base = base & ~32'h1F;
        ld_n = (n > DEPTH) ? DEPTH : n;
        start = 1; start_base_addr = base; start_num_inst = 12'(n);
        @(posedge clk); #2 start_cyc = cyc;
        @(negedge clk); start = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (ds_cnt > ds0) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok)
            for (int k = 0; k < ld_n; k++) begin
                exp_mem[k] = ddr_word((ld_base >> 2) + k);
                exp_valid[k] = 1;
            end
    endtask

    task automatic read_word(input int a, output logic [31:0] d);
        @(negedge clk); s_read_req_b = 1; s_read_addr_b = 11'(a);
        @(negedge clk); d = s_read_data_b; s_read_req_b = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        checks++; if (start_ready !== 1'b1) begin failures++;
            $display("FAIL rst_start_ready got %0b want 1", start_ready); end
        checks++; if (m.arvalid !== 1'b0) begin failures++;
            $display("FAIL rst_arvalid got %0b want 0", m.arvalid); end
        checks++; if (m.rready !== 1'b0) begin failures++;
            $display("FAIL rst_rready got %0b want 0", m.rready); end
        checks++; if (decoder_start !== 1'b0) begin failures++;
            $display("FAIL rst_dstart got %0b want 0", decoder_start); end
        checks++; if (load_error !== 1'b0) begin failures++;
            $display("FAIL rst_err got %0b want 0", load_error); end
        checks++; if (m.araddr !== 32'h0 || m.arlen !== 8'h0) begin failures++;
            $display("FAIL rst_ar got %0h/%0h want 0/0", m.araddr, m.arlen); end
        checks++; if (s_read_data_b !== 32'h0) begin failures++;
            $display("FAIL rst_rdata got %0h want 0", s_read_data_b); end
    endtask

    task automatic test_big;
        bit ok;
        int beats, nexp, nb, len;
        int ra[8];
        logic [31:0] d;
        gap_pct = 0; ar_delay = 0;
        start_load(32'h00DF6BC0, 2080, ok);
        wait_done(20000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL big_done got timeout want decoder_start"); end
        beats = (ld_n + WPB - 1) / WPB;
        nexp = (beats + 15) / 16;
        nb = ar_len_q.size() - ar0;
        checks++; if (nb != nexp) begin failures++;
            $display("FAIL big_bursts got %0d want %0d", nb, nexp); end
        for (int b = 0; b < nexp && b < nb; b++) begin
            len = ((beats - 16*b) > 16 ? 16 : beats - 16*b) - 1;
            checks++;
            if (ar_len_q[ar0+b] != len ||
                ar_addr_q[ar0+b] !== ld_base + 32'(b * 512)) begin
                failures++;
                $display("FAIL big_ar%0d got %0h/%0d want %0h/%0d", b,
                         ar_addr_q[ar0+b], ar_len_q[ar0+b],
                         ld_base + 32'(b * 512), len);
            end
        end
        repeat (5) @(negedge clk);
        checks++; if (ds_cnt - ds0 != 1) begin failures++;
            $display("FAIL big_dstart got %0d want 1", ds_cnt - ds0); end
        checks++; if (load_error !== 1'b0) begin failures++;
            $display("FAIL big_err got %0b want 0", load_error); end
        ra = '{0, 7, 8, 2047, 0, 0, 0, 0};
        for (int i = 4; i < 8; i++) ra[i] = int'($urandom_range(2047));
        for (int i = 0; i < 8; i++) begin
            read_word(ra[i], d);
            checks++; if (d !== exp_mem[ra[i]]) begin failures++;
                $display("FAIL big_rd[%0d] got %0h want %0h",
                         ra[i], d, exp_mem[ra[i]]); end
        end
    endtask

    task automatic test_partial;
        bit ok;
        logic [31:0] d;
        start_load(32'h0001005D, 13, ok);
        wait_done(500, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL part_done got timeout want decoder_start"); end
        checks++;
        if (ar_len_q.size() - ar0 != 1 || ar_len_q[ar0] != 1 ||
            ar_addr_q[ar0] !== 32'h00010040) begin
            failures++;
            $display("FAIL part_ar got n=%0d want one burst len 1 at 10040",
                     ar_len_q.size() - ar0);
        end
        for (int a = 0; a < 14; a++) begin
            read_word(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++;
                $display("FAIL part_rd[%0d] got %0h want %0h",
                         a, d, exp_mem[a]); end
        end
    endtask

    task automatic test_read_conflict;
        bit ok, got;
        int bad_rd, viol;
        logic [31:0] old0, d;
        gap_pct = 30;
        old0 = exp_mem[0];
        start_load($urandom & 32'h00FFFFE0, 40, ok);
        for (int i = 0; i < 100 && ar_len_q.size() == ar0; i++)
            @(negedge clk);
        checks++; if (ar_len_q.size() == ar0) begin failures++;
            $display("FAIL conf_ar got no AR want one"); end
        got = 0; bad_rd = 0; viol = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk); #1;
            if (i > 0 && s_read_data_b !== old0) bad_rd++;
            if (got && m.rready) viol++;
            if (m.rvalid && m.rready) got = 1;
            s_read_req_b = (i < 20); s_read_addr_b = '0;
        end
        checks++; if (!got) begin failures++;
            $display("FAIL conf_beat got 0 want 1 accepted beat"); end
        checks++; if (viol != 0) begin failures++;
            $display("FAIL conf_rready got %0d high cycles want 0", viol); end
        checks++; if (bad_rd != 0) begin failures++;
            $display("FAIL conf_nowrite got %0d changed reads want 0", bad_rd); end
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL conf_done got timeout want decoder_start"); end
        for (int a = 0; a <= 40; a++) begin
            read_word(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++;
                $display("FAIL conf_rd[%0d] got %0h want %0h",
                         a, d, exp_mem[a]); end
        end
    endtask

    task automatic test_busy;
        bit ok;
        gap_pct = 0;
        start_load(32'h00200000, 24, ok);
        checks++; if (start_ready !== 1'b0) begin failures++;
            $display("FAIL busy_ready got %0b want 0", start_ready); end
        start = 1; start_num_inst = '0;
        @(negedge clk); start = 0;
        wait_done(500, ok);
        repeat (6) @(negedge clk);
        checks++; if (!ok || ds_cnt - ds0 != 1) begin failures++;
            $display("FAIL busy_dstart got %0d want 1", ds_cnt - ds0); end
        checks++; if (ar_len_q.size() - ar0 != 1) begin failures++;
            $display("FAIL busy_bursts got %0d want 1", ar_len_q.size() - ar0); end
    endtask

    task automatic test_zero;
        bit ok;
        int a0;
        a0 = arv_cnt;
        start_load(32'h00300000, 0, ok);
        wait_done(20, ok);
        checks++; if (!ok || ds_cyc != start_cyc) begin failures++;
            $display("FAIL zero_dstart got cyc %0d want %0d", ds_cyc, start_cyc); end
        repeat (4) @(negedge clk);
        checks++; if (arv_cnt != a0 || ar_len_q.size() != ar0) begin failures++;
            $display("FAIL zero_noar got %0d arvalid cycles want 0", arv_cnt - a0); end
    endtask

    task automatic test_error;
        bit ok;
        int a;
        logic [31:0] d;
        gap_pct = 20;
        err_beat = beats_sent + 3;
        start_load(32'h00400020, 64, ok);
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL err_done got timeout want decoder_start"); end
        checks++; if (load_error !== 1'b1) begin failures++;
            $display("FAIL err_flag got %0b want 1", load_error); end
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(63));
            read_word(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++;
                $display("FAIL err_rd[%0d] got %0h want %0h", a, d, exp_mem[a]); end
        end
        err_beat = -1;
        start_load(32'h00500000, 5, ok);
        checks++; if (load_error !== 1'b0) begin failures++;
            $display("FAIL err_clear got %0b want 0", load_error); end
        checks++; if (m.arvalid !== 1'b1) begin failures++;
            $display("FAIL err_arvalid got %0b want 1", m.arvalid); end
        wait_done(500, ok);
        checks++; if (!ok || load_error !== 1'b0) begin failures++;
            $display("FAIL err_second got ok=%0b err=%0b want 1/0", ok, load_error); end
    endtask

    task automatic test_reset_midburst;
        bit ok;
        int u0, b0;
        logic [31:0] d;
        ar_delay = 5; gap_pct = 40;
        u0 = ar_unstable; b0 = beats_sent;
        start_load(32'h00600000, 200, ok);
        for (int i = 0; i < 500 && beats_sent < b0 + 3; i++) @(negedge clk);
        checks++; if (beats_sent < b0 + 3) begin failures++;
            $display("FAIL mid_beats got %0d want >=3", beats_sent - b0); end
        checks++; if (ar_unstable != u0) begin failures++;
            $display("FAIL mid_stable got %0d changes want 0", ar_unstable - u0); end
        reset = 1;
        @(posedge clk); #1;
        checks++;
        if (m.arvalid !== 0 || m.rready !== 0 || start_ready !== 1 ||
            decoder_start !== 0 || load_error !== 0) begin
            failures++;
            $display("FAIL mid_ctl got av%0b rr%0b sr%0b ds%0b le%0b want 0 0 1 0 0",
                     m.arvalid, m.rready, start_ready, decoder_start, load_error);
        end
        checks++;
        if (m.araddr !== 0 || m.arlen !== 0 || s_read_data_b !== 0) begin
            failures++;
            $display("FAIL mid_data got %0h/%0h/%0h want 0/0/0",
                     m.araddr, m.arlen, s_read_data_b);
        end
        @(negedge clk); @(negedge clk); reset = 0;
        for (int k = 0; k < 200; k++) exp_valid[k] = 0;
        checks++; if (ds_cnt != ds0) begin failures++;
            $display("FAIL mid_nodone got %0d want 0", ds_cnt - ds0); end
        start_load(32'h00700100, 8, ok);
        wait_done(500, ok);
        checks++;
        if (!ok || ar_len_q.size() - ar0 != 1 || ar_len_q[ar0] != 0) begin
            failures++;
            $display("FAIL mid_reload got ok=%0b bursts=%0d want 1/1",
                     ok, ar_len_q.size() - ar0);
        end
        for (int a = 0; a < 8; a++) begin
            read_word(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++;
                $display("FAIL mid_rd[%0d] got %0h want %0h", a, d, exp_mem[a]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_big();
        test_partial();
        test_read_conflict();
        test_busy();
        test_zero();
        test_error();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
